// File: rtl/busy_rr_sched.sv
// busy_rr_sched
//   Round-robin scheduler that shares one fixed-duration busy resource among
//   NREQ requesters. Each grant launches the resource with a one-cycle
//   o_start pulse, holds the busy window for MAX_AMOUNT-1 cycles using an
//   internal countdown, acknowledges the owner, then re-arbitrates.
//
// Parameters
//   NREQ        number of requesters, 2..16
//   MAX_AMOUNT  busy window length (o_busy high MAX_AMOUNT-1 cycles), 2..65535
//
// Ports
//   i_clk      in   1              clock, all logic on posedge
//   i_reset_n  in   1              synchronous active-low reset
//   i_req      in   NREQ           per-requester request, held until its o_ack
//   o_grant    out  NREQ           one-hot owner while the window is busy
//   o_owner    out  clog2(NREQ)    binary index of current/last owner
//   o_start    out  1              one-cycle pulse on the first cycle of a grant
//   o_busy     out  1              resource busy (countdown != 0)
//   o_ack      out  NREQ           one-cycle one-hot completion pulse to owner

module busy_rr_sched #(
    parameter int NREQ       = 4,
    parameter int MAX_AMOUNT = 22
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic [NREQ-1:0]         i_req,
    output logic [NREQ-1:0]         o_grant,
    output logic [$clog2(NREQ)-1:0] o_owner,
    output logic                    o_start,
    output logic                    o_busy,
    output logic [NREQ-1:0]         o_ack
);

    localparam int OW = $clog2(NREQ);
    // One extra bit so pointer + offset (up to 2*NREQ-1) cannot overflow.
    localparam int CW = OW + 1;
    localparam logic [15:0] LOAD_VAL = 16'(MAX_AMOUNT - 1);

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("busy_rr_sched: NREQ must be in 2..16");
    end
    if (MAX_AMOUNT < 2 || MAX_AMOUNT > 65535) begin : g_bad_max
        $error("busy_rr_sched: MAX_AMOUNT must be in 2..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     count_q, count_d;
    logic [OW-1:0]   ptr_q,   ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q,   ack_d;
    logic            start_q, start_d;
    logic            busy_q,  busy_d;

    // Round-robin pick: first requester above the pointer, wrapping around.
    // The pointer itself is checked last, so the previous owner has lowest
    // priority on the next arbitration.
    logic          win_found;
    logic [OW-1:0] win_idx;
    logic [CW-1:0] cand;

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!win_found && i_req[cand[OW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[OW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        ack_d   = '0;
        start_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_BUSY;
                    count_d = LOAD_VAL;
                    ptr_d   = win_idx;
                    owner_d = win_idx;
                    grant_d = NREQ'(1) << win_idx;
                    start_d = 1'b1;
                end
            end
            ST_BUSY: begin
                // Window is non-abortable: requests are not looked at here.
                // The count is always >= 1 in this state, so it cannot wrap.
                count_d = count_q - 16'd1;
                if (count_q == 16'd1) begin
                    state_d = ST_DONE;
                    grant_d = '0;
                    ack_d   = grant_q;
                end
            end
            ST_DONE: begin
                // Dead cycle so the acknowledged owner can drop its request
                // before IDLE samples again.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                grant_d = '0;
            end
        endcase

        busy_d = (count_d != 16'd0);
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values; reset here is synchronous and wins over everything.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ptr_q   <= OW'(NREQ - 1);
            owner_q <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign o_grant = grant_q;
    assign o_owner = owner_q;
    assign o_start = start_q;
    assign o_busy  = busy_q;
    assign o_ack   = ack_q;

endmodule

// File: tb/tb_busy_rr_sched.sv
// tb_busy_rr_sched
//   Directed bench for busy_rr_sched (NREQ=4, MAX_AMOUNT=22). A cycle-level
//   model describes each grant as a start cycle plus fixed offsets, and a
//   compare process checks every DUT output against it on each negedge.
//   Directed scenarios add hand-computed cycle numbers and the full grant order.

module tb_busy_rr_sched;

    localparam int NREQ = 4;
    localparam int MAXA = 22;
    localparam int OW   = $clog2(NREQ);

    logic            i_clk;
    logic            i_reset_n;
    logic [NREQ-1:0] i_req;
    logic [NREQ-1:0] o_grant;
    logic [OW-1:0]   o_owner;
    logic            o_start;
    logic            o_busy;
    logic [NREQ-1:0] o_ack;

    busy_rr_sched #(.NREQ(NREQ), .MAX_AMOUNT(MAXA)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     (i_req),
        .o_grant   (o_grant),
        .o_owner   (o_owner),
        .o_start   (o_start),
        .o_busy    (o_busy),
        .o_ack     (o_ack)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A grant made at cycle S owns the resource for cycles S..S+MAXA-2, is
    // acknowledged at S+MAXA-1, and the next arbitration can launch at S+MAXA+1.
    bit m_valid  = 1'b0;
    bit m_active = 1'b0;
    int m_start  = 0;
    int m_last   = NREQ - 1;
    int m_owner  = 0;
    int model_log[$];

    initial forever begin
        @(posedge i_clk);
        cyc++;
        if (!i_reset_n) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_last   = NREQ - 1;
            m_owner  = 0;
        end else if ((!m_active || cyc >= m_start + MAXA + 1) && i_req != '0) begin
            int  win;
            bit  found;
            win   = 0;
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (!found && i_req[c]) begin
                    found = 1'b1;
                    win   = c;
                end
            end
            m_active = 1'b1;
            m_start  = cyc;
            m_last   = win;
            m_owner  = win;
            model_log.push_back(win);
        end
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge i_clk);
        if (m_valid) begin
            logic [31:0] e_grant, e_ack, e_start, e_busy;
            int e;
            e       = cyc - m_start;
            e_grant = '0;
            e_ack   = '0;
            e_start = '0;
            e_busy  = '0;
            if (m_active && e <= MAXA - 2) begin
                e_grant = 32'(1) << m_last;
                e_busy  = 32'd1;
                e_start = (e == 0) ? 32'd1 : 32'd0;
            end
            if (m_active && e == MAXA - 1) begin
                e_ack = 32'(1) << m_last;
            end
            check("grant", 32'(o_grant), e_grant);
            check("owner", 32'(o_owner), 32'(m_owner));
            check("start", 32'(o_start), e_start);
            check("busy",  32'(o_busy),  e_busy);
            check("ack",   32'(o_ack),   e_ack);
        end
    end

    // ---------------- monitor ----------------
    int dut_owner_log[$];
    int dut_start_cyc[$];
    int busy_cnt  = 0;
    int last_busy = 0;

    initial forever begin
        @(negedge i_clk);
        if (o_start === 1'b1) begin
            dut_owner_log.push_back(int'(o_owner));
            dut_start_cyc.push_back(cyc);
        end
        if (o_busy === 1'b1) begin
            busy_cnt++;
            last_busy = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a, output int c);
        bit seen;
        seen = 1'b0;
        a    = '0;
        c    = -1;
        for (int k = 0; k < 64; k++) begin
            if (!seen) begin
                tick();
                if (o_ack != '0) begin
                    seen = 1'b1;
                    a    = o_ack;
                    c    = cyc;
                end
            end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL ack_timeout @cycle %0d: got no o_ack, expected one within 64 cycles", cyc);
        end
    endtask

    // Serve n grants. Each acknowledged owner drops its request in the IDLE
    // cycle and, if persist, raises it again one cycle later. After the last
    // acknowledge the request vector becomes last_req.
    task automatic serve(input int n, input bit persist, input logic [NREQ-1:0] last_req,
                         output logic [NREQ-1:0] first_a, output int first_c);
        logic [NREQ-1:0] a;
        int c;
        first_a = '0;
        first_c = -1;
        for (int k = 0; k < n; k++) begin
            wait_ack(a, c);
            if (k == 0) begin
                first_a = a;
                first_c = c;
            end
            tick();
            if (k == n - 1) begin
                i_req = last_req;
            end else begin
                i_req = i_req & ~a;
                tick();
                if (persist) i_req = i_req | a;
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [NREQ-1:0] a;
        int c;
        int n0;
        int exp_order[15];

        i_reset_n = 1'b0;
        i_req     = '0;
        repeat (3) tick();
        i_reset_n = 1'b1;
        tick();

        // Reset state.
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_owner", 32'(o_owner), 32'd0);
        check("rst_busy",  32'(o_busy),  32'd0);

        // T1: single requester 0.
        n0 = cyc;
        busy_cnt = 0;
        i_req = 4'b0001;
        serve(1, 1'b0, 4'b0000, a, c);
        check("t1_ack_val",   32'(a), 32'h1);
        check("t1_ack_cyc",   32'(c), 32'(n0 + 22));
        check("t1_start_cyc", 32'(dut_start_cyc[dut_start_cyc.size() - 1]), 32'(n0 + 1));
        check("t1_busy_len",  32'(busy_cnt), 32'd21);
        check("t1_busy_last", 32'(last_busy), 32'(n0 + 21));

        // T2: requesters 1 and 2 contend, re-raising after each acknowledge.
        i_req = 4'b0110;
        serve(4, 1'b1, 4'b0000, a, c);
        check("t2_first_ack", 32'(a), 32'h2);
        // Back-to-back grants: one DONE and one IDLE cycle after the window.
        for (int k = 2; k <= 4; k++) begin
            if (k < dut_start_cyc.size()) begin
                check("t2_start_gap", 32'(dut_start_cyc[k] - dut_start_cyc[k - 1]), 32'(MAXA + 1));
            end
        end

        // T4: owner 2 drops its request mid-window; the window still completes.
        n0 = cyc;
        busy_cnt = 0;
        i_req = 4'b0100;
        repeat (5) tick();
        i_req = 4'b0000;
        wait_ack(a, c);
        check("t4_ack_val",   32'(a), 32'h4);
        check("t4_ack_cyc",   32'(c), 32'(n0 + 22));
        check("t4_busy_len",  32'(busy_cnt), 32'd21);
        check("t4_busy_last", 32'(last_busy), 32'(n0 + 21));
        tick();

        // T5: reset in the middle of requester 1's window.
        n0 = cyc;
        i_req = 4'b0010;
        repeat (10) tick();
        i_reset_n = 1'b0;
        tick();
        check("t5_grant", 32'(o_grant), 32'd0);
        check("t5_owner", 32'(o_owner), 32'd0);
        check("t5_start", 32'(o_start), 32'd0);
        check("t5_busy",  32'(o_busy),  32'd0);
        check("t5_ack",   32'(o_ack),   32'd0);
        i_reset_n = 1'b1;
        i_req = 4'b1111;

        // T3: everyone requests; after reset the order starts at requester 0.
        serve(5, 1'b1, 4'b1000, a, c);
        check("t5_first_ack_val", 32'(a), 32'h1);
        check("t5_first_ack_cyc", 32'(c), 32'(n0 + 33));
        serve(1, 1'b0, 4'b0000, a, c);
        check("t3_owner3_ack", 32'(a), 32'h8);

        // T6: last owner 3, requests 0 and 3 -> wrap to 0, then 3.
        i_req = 4'b1001;
        serve(2, 1'b0, 4'b0000, a, c);
        check("t6_first_ack", 32'(a), 32'h1);
        repeat (3) tick();

        exp_order = '{0, 1, 2, 1, 2, 2, 1, 0, 1, 2, 3, 0, 3, 0, 3};
        check("dut_grant_count",   32'(dut_owner_log.size()), 32'd15);
        check("model_grant_count", 32'(model_log.size()),     32'd15);
        for (int k = 0; k < 15; k++) begin
            if (k < dut_owner_log.size()) check("dut_grant_order", 32'(dut_owner_log[k]), 32'(exp_order[k]));
            if (k < model_log.size())     check("model_grant_order", 32'(model_log[k]), 32'(exp_order[k]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
